// File: rtl/pipeline_issuer_if.sv
// Command, issue, flush and retire signals between the issuer and the pipeline it drives.
// Widths come from ADDRESS_WIDTH / ID_WIDTH; the fallback defaults here keep standalone builds working.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

interface pipeline_issuer_if;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [`ADDRESS_WIDTH-1:0] cmd_base_address;
  logic [7:0]                cmd_count;
  logic [`ADDRESS_WIDTH-1:0] out_address;
  logic [`ID_WIDTH-1:0]      out_id;
  logic                      out_valid;
  logic                      in_stall;
  logic                      out_flush;
  logic [`ID_WIDTH-1:0]      out_flush_id;
  logic                      in_ret_valid;
  logic [`ID_WIDTH-1:0]      in_ret_id;

  modport master (
    input  cmd_valid, cmd_base_address, cmd_count, in_stall, in_ret_valid, in_ret_id,
    output cmd_ready, out_address, out_id, out_valid, out_flush, out_flush_id
  );

  modport slave (
    output cmd_valid, cmd_base_address, cmd_count, in_stall, in_ret_valid, in_ret_id,
    input  cmd_ready, out_address, out_id, out_valid, out_flush, out_flush_id
  );
endinterface

// File: rtl/pipeline_issuer.sv
// Burst address issuer with credit limit, in-order retire tracking and timeout flush by ID.
// Optional perf counters are built only when ISSUER_PERF_EN is defined.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module pipeline_issuer #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                clk,
  input  logic                reset,
  pipeline_issuer_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic                order_err,
  output logic [15:0]         perf_stall_cycles,
  output logic [15:0]         perf_retired
);
  localparam int AW   = `ADDRESS_WIDTH;
  localparam int IW   = `ID_WIDTH;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic [IW-1:0]   next_id, oldest_id, outstanding;
  logic [IW-1:0]   flush_cnt, flush_id_q;
  logic [7:0]      remaining;
  logic [WD_W-1:0] watchdog;
  logic            flush_q, done_q, timeout_err_q, order_err_q;
  logic            active, xfer, ret_ok, ret_bad, timeout;

  always_comb begin
    active  = (state == ISSUE) || (state == DRAIN);
    xfer    = bus.out_valid && !bus.in_stall;
    ret_ok  = active && bus.in_ret_valid && (bus.in_ret_id == oldest_id) && (outstanding != '0);
    ret_bad = active && bus.in_ret_valid && !ret_ok;
    timeout = active && (outstanding != '0) && !ret_ok && (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.cmd_valid && (bus.cmd_count != 8'd0)) state_nxt = ISSUE;
      ISSUE: if (timeout) state_nxt = FLUSH;
             else if (xfer && (remaining == 8'd1)) state_nxt = DRAIN;
      DRAIN: if (timeout) state_nxt = FLUSH;
             else if (outstanding == '0) state_nxt = IDLE;
      FLUSH: if (flush_cnt == outstanding) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE) && !reset;
    bus.out_valid = (state == ISSUE) && (remaining != 8'd0) &&
                    (outstanding < IW'(MAX_OUTSTANDING));
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      next_id       <= '0;
      oldest_id     <= '0;
      outstanding   <= '0;
      remaining     <= '0;
      watchdog      <= '0;
      flush_cnt     <= '0;
      flush_id_q    <= '0;
      flush_q       <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      order_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_count != 8'd0) begin
              addr_q    <= bus.cmd_base_address;
              remaining <= bus.cmd_count;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE, DRAIN: begin
          if (xfer) begin
            addr_q    <= addr_q + AW'(1);
            next_id   <= next_id + IW'(1);
            remaining <= remaining - 8'd1;
          end
          if (ret_ok)  oldest_id   <= oldest_id + IW'(1);
          if (ret_bad) order_err_q <= 1'b1;
          outstanding <= outstanding + IW'(xfer) - IW'(ret_ok);
          if (ret_ok || (outstanding == '0)) watchdog <= '0;
          else if (!timeout)                 watchdog <= watchdog + WD_W'(1);
          // A transfer on the timeout edge was accepted downstream, so it is counted and flushed too.
          if (timeout) begin
            flush_q    <= 1'b1;
            flush_id_q <= oldest_id;
            flush_cnt  <= IW'(1);
            watchdog   <= '0;
          end
          if ((state == DRAIN) && (outstanding == '0)) done_q <= 1'b1;
        end
        FLUSH: begin
          if (flush_cnt == outstanding) begin
            flush_q       <= 1'b0;
            outstanding   <= '0;
            oldest_id     <= next_id;
            timeout_err_q <= 1'b1;
            done_q        <= 1'b1;
          end else begin
            flush_id_q <= oldest_id + flush_cnt;
            flush_cnt  <= flush_cnt + IW'(1);
          end
        end
      endcase
    end
  end

  assign bus.out_address  = addr_q;
  assign bus.out_id       = next_id;
  assign bus.out_flush    = flush_q;
  assign bus.out_flush_id = flush_id_q;
  assign done             = done_q;
  assign timeout_err      = timeout_err_q;
  assign order_err        = order_err_q;

`ifdef ISSUER_PERF_EN
  logic [15:0] stall_cnt, ret_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (bus.out_valid && bus.in_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (ret_ok && (ret_cnt != 16'hFFFF))                          ret_cnt   <= ret_cnt + 16'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_retired      = ret_cnt;
`else
  assign perf_stall_cycles = '0;
  assign perf_retired      = '0;
`endif
endmodule

// File: tb/tb_pipeline_issuer.sv
// Directed testbench for pipeline_issuer: burst issue, stall, credits, wrap, timeout flush, order error.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module tb_pipeline_issuer;
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy, done, timeout_err, order_err;
  logic [15:0] perf_stall_cycles, perf_retired;
  int          checks = 0;
  int          failures = 0;

  pipeline_issuer_if bus();

  pipeline_issuer #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .done(done),
    .timeout_err(timeout_err), .order_err(order_err),
    .perf_stall_cycles(perf_stall_cycles), .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [AW-1:0] base, input logic [7:0] cnt);
    bus.cmd_valid = 1'b1;
    bus.cmd_base_address = base;
    bus.cmd_count = cnt;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic retire(input logic [IW-1:0] id);
    bus.in_ret_valid = 1'b1;
    bus.in_ret_id = id;
    tick();
    bus.in_ret_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    reset = 1'b1;
    tick();
    tick();
    flags = {bus.cmd_ready, bus.out_valid, busy, done, bus.out_flush, timeout_err, order_err};
    checks++; if (flags !== 7'b0) begin failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 7'b0); end
    checks++; if ({bus.out_address, bus.out_id} !== '0) begin failures++;
      $display("FAIL reset_addr_id got=%h/%h exp=0/0", bus.out_address, bus.out_id); end
    checks++; if ({perf_stall_cycles, perf_retired} !== 32'd0) begin failures++;
      $display("FAIL reset_perf got=%h exp=0", {perf_stall_cycles, perf_retired}); end
    reset = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_zero_count();
    start_cmd(16'h0055, 8'd0);
    checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL zero_done got=%b exp=10", {done, busy}); end
    tick();
    checks++; if ({done, bus.cmd_ready} !== 2'b01) begin failures++;
      $display("FAIL zero_after got=%b exp=01", {done, bus.cmd_ready}); end
  endtask

  task automatic test_basic();
    start_cmd(16'h0010, 8'd3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_address !== AW'(16'h0010 + k) || bus.out_id !== IW'(k)) begin
        failures++;
        $display("FAIL basic_issue%0d got=%b/%h/%h exp=1/%h/%h", k, bus.out_valid, bus.out_address,
                 bus.out_id, AW'(16'h0010 + k), IW'(k));
      end
      tick();
    end
    checks++; if ({bus.out_valid, busy} !== 2'b01) begin failures++;
      $display("FAIL basic_drain got=%b exp=01", {bus.out_valid, busy}); end
    tick();
    tick();
    retire(IW'(0));
    retire(IW'(1));
    retire(IW'(2));
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_early_done got=%b exp=0", done); end
    tick();
    checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL basic_done got=%b exp=10", {done, busy}); end
    tick();
    checks++; if ({done, order_err, timeout_err} !== 3'b000) begin failures++;
      $display("FAIL basic_after got=%b exp=000", {done, order_err, timeout_err}); end
  endtask

  task automatic test_stall();
    start_cmd(16'h0040, 8'd2);
    checks++; if (bus.out_id !== IW'(3) || bus.out_address !== AW'(16'h0040)) begin failures++;
      $display("FAIL stall_first got=%h/%h exp=3/0040", bus.out_id, bus.out_address); end
    tick();
    bus.in_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_address !== AW'(16'h0041) || bus.out_id !== IW'(4)) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/0041/4", i, bus.out_valid, bus.out_address, bus.out_id);
      end
    end
    bus.in_stall = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_id !== IW'(5)) begin failures++;
      $display("FAIL stall_release got=%b/%h exp=0/5", bus.out_valid, bus.out_id); end
`ifdef ISSUER_PERF_EN
    checks++; if (perf_stall_cycles !== 16'd4) begin failures++; $display("FAIL perf_stall got=%0d exp=4", perf_stall_cycles); end
`else
    checks++; if (perf_stall_cycles !== 16'd0) begin failures++; $display("FAIL perf_stall got=%0d exp=0", perf_stall_cycles); end
`endif
    retire(IW'(3));
    retire(IW'(4));
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
  endtask

  task automatic test_credit();
    start_cmd(16'h0100, 8'd6);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(5 + k) || bus.out_address !== AW'(16'h0100 + k)) begin
        failures++;
        $display("FAIL credit_issue%0d got=%b/%h/%h exp=1/%h/%h", k, bus.out_valid, bus.out_id,
                 bus.out_address, IW'(5 + k), AW'(16'h0100 + k));
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL credit_block%0d got=%b exp=0", i, bus.out_valid); end
      tick();
    end
    retire(IW'(5));
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(9) || bus.out_address !== AW'(16'h0104)) begin failures++;
      $display("FAIL credit_resume1 got=%b/%h/%h exp=1/9/0104", bus.out_valid, bus.out_id, bus.out_address); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_id !== IW'(10)) begin failures++;
      $display("FAIL credit_one_per_retire got=%b/%h exp=0/a", bus.out_valid, bus.out_id); end
    retire(IW'(6));
    checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(10) || bus.out_address !== AW'(16'h0105)) begin failures++;
      $display("FAIL credit_resume2 got=%b/%h/%h exp=1/a/0105", bus.out_valid, bus.out_id, bus.out_address); end
    tick();
    checks++; if ({bus.out_valid, busy} !== 2'b01) begin failures++;
      $display("FAIL credit_drain got=%b exp=01", {bus.out_valid, busy}); end
    for (int k = 7; k <= 10; k++) retire(IW'(k));
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL credit_done got=%b exp=1", done); end
`ifdef ISSUER_PERF_EN
    checks++; if (perf_retired !== 16'd11) begin failures++; $display("FAIL perf_retired got=%0d exp=11", perf_retired); end
`else
    checks++; if (perf_retired !== 16'd0) begin failures++; $display("FAIL perf_retired got=%0d exp=0", perf_retired); end
`endif
  endtask

  task automatic test_wrap();
    start_cmd(16'hFFFF, 8'd2);
    checks++; if (bus.out_address !== 16'hFFFF || bus.out_id !== IW'(11)) begin failures++;
      $display("FAIL wrap_first got=%h/%h exp=ffff/b", bus.out_address, bus.out_id); end
    tick();
    checks++; if (bus.out_address !== 16'h0000 || bus.out_id !== IW'(12) || bus.out_valid !== 1'b1) begin failures++;
      $display("FAIL wrap_second got=%h/%h/%b exp=0000/c/1", bus.out_address, bus.out_id, bus.out_valid); end
    tick();
    retire(IW'(11));
    retire(IW'(12));
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", done); end
  endtask

  task automatic test_timeout();
    logic seen_flush;
    start_cmd(16'h0200, 8'd3);
    checks++; if (bus.out_id !== IW'(13)) begin failures++; $display("FAIL to_first_id got=%h exp=d", bus.out_id); end
    tick(); tick(); tick();
    seen_flush = 1'b0;
    for (int i = 0; i < 61; i++) begin
      tick();
      seen_flush = seen_flush | bus.out_flush;
    end
    checks++; if ({seen_flush, busy} !== 2'b01) begin failures++;
      $display("FAIL to_early_flush got=%b exp=01", {seen_flush, busy}); end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (bus.out_flush !== 1'b1 || bus.out_flush_id !== IW'(13 + j) || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL to_flush%0d got=%b/%h/%b exp=1/%h/0", j, bus.out_flush, bus.out_flush_id, bus.out_valid, IW'(13 + j));
      end
    end
    tick();
    checks++; if ({bus.out_flush, done, timeout_err, busy} !== 4'b0110) begin failures++;
      $display("FAIL to_end got=%b exp=0110", {bus.out_flush, done, timeout_err, busy}); end
    tick();
    start_cmd(16'h0300, 8'd1);
    checks++; if (bus.out_id !== IW'(0) || bus.out_address !== AW'(16'h0300)) begin failures++;
      $display("FAIL to_next_burst got=%h/%h exp=0/0300", bus.out_id, bus.out_address); end
    tick();
    retire(IW'(0));
    tick();
    checks++; if ({done, timeout_err, order_err} !== 3'b110) begin failures++;
      $display("FAIL to_next_done got=%b exp=110", {done, timeout_err, order_err}); end
  endtask

  task automatic test_order();
    start_cmd(16'h0400, 8'd2);
    tick();
    tick();
    retire(IW'(2));
    checks++; if (order_err !== 1'b1) begin failures++; $display("FAIL order_flag got=%b exp=1", order_err); end
    retire(IW'(1));
    tick();
    checks++; if ({done, busy} !== 2'b01) begin failures++; $display("FAIL order_count_kept got=%b exp=01", {done, busy}); end
    retire(IW'(2));
    tick();
    checks++; if ({done, order_err} !== 2'b11) begin failures++; $display("FAIL order_done got=%b exp=11", {done, order_err}); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] flags;
    start_cmd(16'h0500, 8'd3);
    tick();
    reset = 1'b1;
    tick();
    flags = {bus.cmd_ready, bus.out_valid, busy, done, bus.out_flush, timeout_err, order_err};
    checks++; if (flags !== 7'b0 || bus.out_id !== '0) begin failures++;
      $display("FAIL midreset_flags got=%b/%h exp=0000000/0", flags, bus.out_id); end
    reset = 1'b0;
    start_cmd(16'h0600, 8'd1);
    checks++; if (bus.out_id !== IW'(0) || bus.out_address !== AW'(16'h0600) || bus.out_flush !== 1'b0) begin failures++;
      $display("FAIL midreset_restart got=%h/%h/%b exp=0/0600/0", bus.out_id, bus.out_address, bus.out_flush); end
    tick();
    retire(IW'(0));
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL midreset_done got=%b exp=1", done); end
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_base_address = '0;
    bus.cmd_count = 8'd0;
    bus.in_stall = 1'b0;
    bus.in_ret_valid = 1'b0;
    bus.in_ret_id = '0;
    test_reset();
    test_zero_count();
    test_basic();
    test_stall();
    test_credit();
    test_wrap();
    test_timeout();
    test_order();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_issuer.md
Name: pipeline_issuer

Overview:
- Head-end source for the stall/flush address pipeline: the producer that drives the first pipeline_stage, and the tail-end retire consumer for the same transactions.
- Accepts a burst command (base address, count) and issues sequential addresses tagged with sequential IDs.
- Honours the first stage's stall, tracks in-flight IDs against in-order retirements from the pipeline tail, and flushes in-flight IDs by ID on a retire timeout.

Parameters:
- MAX_OUTSTANDING, 4: maximum issued-but-unretired transactions, 1..2^`ID_WIDTH-1.
- TIMEOUT_CYCLES, 64: cycles without a retire, while outstanding>0, before flush; must be >=1.
- Address and ID widths come from `ADDRESS_WIDTH and `ID_WIDTH in defines.vh.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  issuer can accept a command
- cmd_base_address  in  `ADDRESS_WIDTH  first address of burst
- cmd_count  in  8  number of transactions; 0 is legal
- out_address  out  `ADDRESS_WIDTH  address to stage 0 in_address
- out_id  out  `ID_WIDTH  ID to stage 0 in_id
- out_valid  out  1  to stage 0 in_valid
- in_stall  in  1  from stage 0 out_stall
- out_flush  out  1  to stage 0 in_flush
- out_flush_id  out  `ID_WIDTH  to stage 0 in_flush_id
- in_ret_valid  in  1  tail stage out_valid
- in_ret_id  in  `ID_WIDTH  tail stage out_id
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst end
- timeout_err  out  1  sticky: a burst ended by timeout flush
- order_err  out  1  sticky: retire ID != oldest outstanding
- perf_stall_cycles  out  16  see Optional Feature
- perf_retired  out  16  see Optional Feature

Behaviour:
- Reset:
  - All outputs 0; cmd_ready=1 in the cycle after reset deasserts.
  - next_id=0, oldest_id=0, outstanding=0, watchdog=0, state=IDLE.
  - Reset mid-burst abandons the burst with no flush issued.
- Transfer rule: a transaction is accepted at a rising edge where out_valid && !in_stall.
  - While in_stall=1, out_address, out_id and out_valid hold stable.
  - out_valid never deasserts without a transfer, except on FLUSH entry.
- IDLE:
  - cmd_ready=1.
  - cmd_valid with cmd_count!=0: latch base and count, go to ISSUE.
  - cmd_valid with cmd_count=0: done pulses the next cycle; stay in IDLE.
- ISSUE:
  - cmd_ready=0.
  - out_valid=1 iff remaining>0 and outstanding<MAX_OUTSTANDING.
  - out_address = (base + k) mod 2^`ADDRESS_WIDTH, where k is the transfer index (wraps silently).
  - out_id = next_id.
  - On each transfer: next_id++ (mod 2^`ID_WIDTH), remaining--, outstanding++.
  - When remaining reaches 0: go to DRAIN.
- DRAIN: outstanding==0 → done pulse, go to IDLE in the same cycle.
- Retire, in ISSUE and DRAIN:
  - in_ret_valid with in_ret_id==oldest_id and outstanding>0: outstanding--, oldest_id++, watchdog cleared.
  - Any other in_ret_valid: set order_err; counters unchanged.
  - Transfer and retire in the same cycle: outstanding unchanged; both IDs advance.
  - in_ret_valid in IDLE or FLUSH: ignored, no error.
- Watchdog:
  - Counts in ISSUE/DRAIN while outstanding>0; cleared on a valid retire or when outstanding==0.
  - When watchdog reaches TIMEOUT_CYCLES-1 with no retire that cycle: go to FLUSH.
- FLUSH:
  - out_valid=0 (an unaccepted pending transaction is dropped).
  - Register outputs out_flush=1 and out_flush_id = oldest_id + j, for j = 0..outstanding-1, one ID per cycle, oldest first.
  - Then: out_flush=0, outstanding=0, oldest_id=next_id, timeout_err=1, done pulse, go to IDLE.
  - Unissued remaining transactions are discarded.
- Sticky errors clear only on reset.
- The next burst continues the ID sequence from next_id; IDs are not reset per burst.

Optional Feature:
- Macro ISSUER_PERF_EN.
- Defined:
  - perf_stall_cycles increments each cycle with out_valid && in_stall.
  - perf_retired increments on each valid in-order retire.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: both outputs tied to 0 and no counter flops exist.

Test Plan:
- Basic burst: base=0x10, count=3, no stall, each retire 5 cycles after issue → addresses 0x10/0x11/0x12, IDs 0/1/2 on consecutive cycles; done pulses once after the ID 2 retire; no errors.
- Stall hold: in_stall=1 for 4 cycles while ID 1 is pending → out_address and out_id stable for all 4 cycles; ID 1 transfers on the first unstalled edge; no ID is skipped.
- Credit limit: count=6, no retires until cycle 20 → out_valid drops after 4 transfers (MAX_OUTSTANDING); resumes one transfer per retire.
- Address wrap: base = all-ones, count=2 → addresses all-ones then 0.
- Timeout: count=3 issued, no retires → after 64 idle cycles out_flush pulses with IDs 0, 1, 2 on consecutive cycles; timeout_err=1; done pulses; next burst starts at ID 3.
- Order error: outstanding IDs 0 and 1, retire ID 1 → order_err=1, outstanding stays 2; a subsequent retire of 0 then 1 completes the burst normally.
